// File: rtl/dff_pipe_sync_reset_pkg.sv
// Shared constants and helpers for the registered delay-line family.
// Imported by the pipeline top and its per-stage register.
package dff_pipe_sync_reset_pkg;

    localparam bit DFF_RESET_ACTIVE_HIGH = 1'b1;

    // Counter width able to hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_sync_reset_en.sv
// WIDTH-bit register with synchronous reset to RESET_VALUE and a load enable.
// One instance per pipeline stage holds that stage's data.
module dff_sync_reset_en
    import dff_pipe_sync_reset_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset == DFF_RESET_ACTIVE_HIGH) begin
            r_q <= RESET_VALUE;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dff_pipe_sync_reset.sv
// WIDTH x DEPTH enable-gated register pipeline with per-stage valid bits,
// synchronous flush and an occupancy counter that tracks popcount(valid).
module dff_pipe_sync_reset
    import dff_pipe_sync_reset_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    localparam int              OCC_W       = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
        $error("dff_pipe_sync_reset: WIDTH and DEPTH must both be >= 1");
    end

    logic                         w_rst;
    logic                         w_adv;
    logic [DEPTH-1:0]             w_ld;
    logic [DEPTH-1:0]             w_v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]  w_d;
    logic [DEPTH-1:0][WIDTH-1:0]  w_q;
    logic [DEPTH-1:0]             r_v;
    logic [OCC_W-1:0]             r_occ;

    assign w_rst = (reset == DFF_RESET_ACTIVE_HIGH);
    assign w_adv = en && !flush;

    // A stage only loads when a valid beat moves into it, so bubbles leave
    // the data flops untouched.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_ld[k] = w_adv && in_valid;
            assign w_d[k]  = in_data;
        end else begin : g_body
            assign w_ld[k] = w_adv && r_v[k-1];
            assign w_d[k]  = w_q[k-1];
        end

        dff_sync_reset_en #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (w_ld[k]),
            .d     (w_d[k]),
            .q     (w_q[k])
        );
    end

    always_comb begin
        w_v_nxt    = r_v << 1;
        w_v_nxt[0] = in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_v   <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_v   <= '0;
            r_occ <= '0;
        end else if (en) begin
            r_v   <= w_v_nxt;
            r_occ <= r_occ + OCC_W'(in_valid) - OCC_W'(r_v[DEPTH-1]);
        end
    end

    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_v[DEPTH-1] ? w_q[DEPTH-1] : RESET_VALUE;
    assign occupancy = r_occ;

endmodule
